// File: rtl/bp_fpga_host_nbf_rx_packer.sv
// Packs the inbound UART byte stream into NBF packets (little-endian byte order) and hands
// them to the NBF FIFO over valid/yumi; partial packets are dropped on rx errors or timeouts.
module bp_fpga_host_nbf_rx_packer #(
    parameter int nbf_addr_width_p = 40,
    parameter int nbf_data_width_p = 64,
    parameter int uart_data_bits_p = 8,
    parameter int timeout_cycles_p = 1000000,
    localparam int nbf_width_lp = 8 + nbf_addr_width_p + nbf_data_width_p,
    localparam int nbf_bytes_lp = nbf_width_lp / 8
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic [uart_data_bits_p-1:0] byte_i,
    input  logic                        byte_v_i,
    output logic                        byte_ready_and_o,
    input  logic                        rx_error_i,
    output logic [nbf_width_lp-1:0]     nbf_o,
    output logic                        nbf_v_o,
    input  logic                        nbf_yumi_i,
    output logic                        error_o,
    output logic [7:0]                  error_count_o
);

    localparam int count_w_lp = $clog2(nbf_bytes_lp);
    localparam int timer_w_lp = (timeout_cycles_p > 2) ? $clog2(timeout_cycles_p) : 1;
    localparam logic [count_w_lp-1:0] last_lp      = count_w_lp'(nbf_bytes_lp - 1);
    localparam logic [timer_w_lp-1:0] timer_max_lp = timer_w_lp'(timeout_cycles_p - 1);

    if (uart_data_bits_p != 8 || (nbf_addr_width_p % 8) != 0 || (nbf_data_width_p % 8) != 0)
    begin : g_param_check
        $error("bp_fpga_host_nbf_rx_packer: byte width must be 8 and NBF widths multiples of 8");
    end

    typedef enum logic {e_idle, e_recv} state_e;

    state_e                    state_q, state_d;
    logic [count_w_lp-1:0]     count_q, count_d;
    logic [timer_w_lp-1:0]     timer_q, timer_d;
    logic [nbf_width_lp-1:0]   acc_q, acc_d;
    logic [nbf_width_lp-1:0]   nbf_q, nbf_d;
    logic                      nbf_v_q, nbf_v_d;
    logic                      error_q, error_d;
    logic [7:0]                error_count_q, error_count_d;
    logic                      ready_q, ready_d;

    logic accept, stall, timeout, discard;

    // Only the final byte can be blocked, and only while the output register is still occupied.
    assign byte_ready_and_o = ready_q & ~((count_q == last_lp) & nbf_v_q & ~nbf_yumi_i);
    assign accept  = byte_v_i & byte_ready_and_o;
    assign stall   = byte_v_i & ~byte_ready_and_o;
    assign timeout = (state_q == e_recv) & (timer_q == timer_max_lp) & ~accept & ~stall;
    assign discard = rx_error_i | timeout;

    always_comb begin
        // NOTE: every _d gets a default first so no path through this block can infer a latch.
        state_d       = state_q;
        count_d       = count_q;
        timer_d       = timer_q;
        acc_d         = acc_q;
        nbf_d         = nbf_q;
        nbf_v_d       = nbf_v_q;
        error_d       = error_q;
        error_count_d = error_count_q;
        ready_d       = 1'b1;

        if (nbf_yumi_i) begin
            nbf_v_d = 1'b0;
        end

        if (discard) begin
            state_d = e_idle;
            count_d = '0;
            timer_d = '0;
            error_d = 1'b1;
            if (error_count_q != 8'hFF) begin
                error_count_d = error_count_q + 8'd1;
            end
        end else if (accept) begin
            acc_d[{count_q, 3'b000} +: 8] = byte_i;
            timer_d = '0;
            if (count_q == last_lp) begin
                nbf_d   = acc_d;
                nbf_v_d = 1'b1;
                count_d = '0;
                state_d = e_idle;
            end else begin
                count_d = count_q + 1'b1;
                state_d = e_recv;
            end
        end else if (state_q == e_recv && !stall) begin
            timer_d = timer_q + 1'b1;
        end
    end

    // NOTE: the accumulator is a plain register, not a memory array, so resetting it is cheap.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q       <= e_idle;
            count_q       <= '0;
            timer_q       <= '0;
            acc_q         <= '0;
            nbf_q         <= '0;
            nbf_v_q       <= 1'b0;
            error_q       <= 1'b0;
            error_count_q <= '0;
            ready_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q       <= state_d;
            count_q       <= count_d;
            timer_q       <= timer_d;
            acc_q         <= acc_d;
            nbf_q         <= nbf_d;
            nbf_v_q       <= nbf_v_d;
            error_q       <= error_d;
            error_count_q <= error_count_d;
            ready_q       <= ready_d;
        end
    end

    assign nbf_o         = nbf_q;
    assign nbf_v_o       = nbf_v_q;
    assign error_o       = error_q;
    assign error_count_o = error_count_q;

endmodule

// File: tb/tb_bp_fpga_host_nbf_rx_packer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue-based model
// of the packer built from the packet/discard rules.
module tb_bp_fpga_host_nbf_rx_packer;

    localparam int NBF_W = 112;
    localparam int NB    = 14;
    localparam int T     = 100;

    typedef logic [NBF_W-1:0] word_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic [7:0]       byte_in = '0;
    logic             byte_v = 1'b0;
    logic             byte_ready;
    logic             rx_error = 1'b0;
    logic [NBF_W-1:0] nbf;
    logic             nbf_v;
    logic             nbf_yumi = 1'b0;
    logic             error_flag;
    logic [7:0]       error_count;

    always #5 clk = ~clk;

    bp_fpga_host_nbf_rx_packer #(
        .nbf_addr_width_p(40),
        .nbf_data_width_p(64),
        .uart_data_bits_p(8),
        .timeout_cycles_p(T)
    ) dut (
        .clk_i           (clk),
        .reset_n_i       (reset_n),
        .byte_i          (byte_in),
        .byte_v_i        (byte_v),
        .byte_ready_and_o(byte_ready),
        .rx_error_i      (rx_error),
        .nbf_o           (nbf),
        .nbf_v_o         (nbf_v),
        .nbf_yumi_i      (nbf_yumi),
        .error_o         (error_flag),
        .error_count_o   (error_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: bytes of the packet in flight, idle-cycle count, output slot.
    logic [7:0] m_bytes[$];
    int         m_idle = 0;
    bit         m_ov = 1'b0;
    word_t      m_pkt = '0;
    bit         m_err = 1'b0;
    logic [7:0] m_cnt = '0;
    bit         m_ready_en = 1'b0;
    bit         m_acc = 1'b0;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_ready(input bit yumi);
        return m_ready_en && !(m_bytes.size() == NB - 1 && m_ov && !yumi);
    endfunction

    task automatic model_clear();
        m_bytes.delete();
        m_idle     = 0;
        m_ov       = 1'b0;
        m_err      = 1'b0;
        m_cnt      = '0;
        m_ready_en = 1'b0;
    endtask

    // One clock: drive inputs, check ready, advance the model at the edge, check outputs.
    task automatic cycle(input bit bv, input logic [7:0] b, input bit rxe, input bit yumi_req);
        bit yumi, rdy, acc, stall, tmo;
        yumi     = yumi_req && m_ov;
        byte_v   = bv;
        byte_in  = b;
        rx_error = rxe;
        nbf_yumi = yumi;
        rdy      = model_ready(yumi);
        #1 check("ready", word_t'(byte_ready), word_t'(rdy));
        @(posedge clk);
        acc   = bv && rdy;
        stall = bv && !rdy;
        tmo   = (m_bytes.size() > 0) && (m_idle == T - 1) && !acc && !stall;
        m_acc = acc;
        if (yumi) m_ov = 1'b0;
        if (rxe || tmo) begin
            m_bytes.delete();
            m_idle = 0;
            m_err  = 1'b1;
            if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
        end else if (acc) begin
            m_bytes.push_back(b);
            m_idle = 0;
            if (m_bytes.size() == NB) begin
                for (int i = 0; i < NB; i++) m_pkt[8*i +: 8] = m_bytes[i];
                m_ov = 1'b1;
                m_bytes.delete();
            end
        end else if (m_bytes.size() > 0 && !stall) begin
            m_idle++;
        end
        m_ready_en = 1'b1;
        @(negedge clk);
        check("nbf_v", word_t'(nbf_v), word_t'(m_ov));
        check("error_o", word_t'(error_flag), word_t'(m_err));
        check("error_count", word_t'(error_count), word_t'(m_cnt));
        if (m_ov) check("nbf_o", nbf, m_pkt);
        byte_v   = 1'b0;
        rx_error = 1'b0;
        nbf_yumi = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rxe, input bit yumi_req);
        int n = 0;
        do begin
            cycle(1'b1, b, rxe, yumi_req);
            n++;
        end while (!m_acc && n < 50);
        check("send_bound", word_t'(m_acc), word_t'(1));
    endtask

    task automatic send_packet(input word_t pkt, input bit yumi_req);
        for (int i = 0; i < NB; i++) send_byte(pkt[8*i +: 8], 1'b0, yumi_req);
    endtask

    function automatic word_t rand_pkt();
        word_t p;
        for (int i = 0; i < NB; i++) p[8*i +: 8] = 8'($urandom);
        return p;
    endfunction

    // Asserts reset between clock edges and checks the outputs drop without waiting for an edge.
    task automatic async_reset(input string tag);
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        check({tag, "_nbf_v"}, word_t'(nbf_v), word_t'(0));
        check({tag, "_error"}, word_t'(error_flag), word_t'(0));
        check({tag, "_count"}, word_t'(error_count), word_t'(0));
        check({tag, "_ready"}, word_t'(byte_ready), word_t'(0));
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1 check({tag, "_rel_ready"}, word_t'(byte_ready), word_t'(0));
    endtask

    initial begin
        word_t exp_pkt;
        word_t first_pkt;
        word_t aa_pkt;

        async_reset("rst0");

        // Single packet 0x00..0x0D with yumi held.
        for (int i = 0; i < NB; i++) exp_pkt[8*i +: 8] = 8'(i);
        send_packet(exp_pkt, 1'b1);
        check("single_v", word_t'(nbf_v), word_t'(1));
        check("single_pkt", nbf, 112'h0D0C0B0A09080706050403020100);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("single_pulse", word_t'(nbf_v), word_t'(0));
        check("single_errcnt", word_t'(error_count), word_t'(0));

        // Backpressure: two packets with no yumi; the final byte of the second stalls.
        first_pkt = rand_pkt();
        aa_pkt    = {NB{8'hAA}};
        send_packet(first_pkt, 1'b0);
        for (int i = 0; i < NB - 1; i++) send_byte(8'hAA, 1'b0, 1'b0);
        repeat (3) begin
            cycle(1'b1, 8'hAA, 1'b0, 1'b0);
            check("bp_ready", word_t'(byte_ready), word_t'(0));
            check("bp_hold", nbf, first_pkt);
        end
        cycle(1'b1, 8'hAA, 1'b0, 1'b1);
        check("bp_refill_v", word_t'(nbf_v), word_t'(1));
        check("bp_refill", nbf, aa_pkt);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("bp_drain", word_t'(nbf_v), word_t'(0));

        // rx error with byte 5 discards the partial packet.
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        send_byte(8'($urandom), 1'b1, 1'b0);
        check("rxerr_flag", word_t'(error_flag), word_t'(1));
        check("rxerr_count", word_t'(error_count), word_t'(1));
        exp_pkt = rand_pkt();
        send_packet(exp_pkt, 1'b0);
        check("rxerr_pkt", nbf, exp_pkt);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Timeout after exactly T idle cycles.
        async_reset("rst_tmo");
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        repeat (T - 1) cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("tmo_before", word_t'(error_count), word_t'(0));
        cycle(1'b0, 8'h00, 1'b0, 1'b0);
        check("tmo_after", word_t'(error_count), word_t'(1));
        check("tmo_flag", word_t'(error_flag), word_t'(1));
        exp_pkt = rand_pkt();
        send_packet(exp_pkt, 1'b0);
        check("tmo_pkt", nbf, exp_pkt);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);

        // Counter saturation, then asynchronous reset mid-packet.
        repeat (300) cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'b1, 1'b0);
        check("sat", word_t'(error_count), word_t'(255));
        for (int i = 0; i < 5; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        async_reset("rst_mid");

        // Reset with a packet held in the output register.
        send_packet(rand_pkt(), 1'b0);
        check("comb_v", word_t'(nbf_v), word_t'(1));
        for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0, 1'b0);
        async_reset("rst_valid");
        exp_pkt = rand_pkt();
        send_packet(exp_pkt, 1'b0);
        check("comb_pkt", nbf, exp_pkt);
        check("comb_errcnt", word_t'(error_count), word_t'(0));

        // Random traffic with occasional errors and long idle gaps.
        repeat (800) begin
            if ($urandom_range(0, 299) == 0) repeat (T + 10) cycle(1'b0, 8'h00, 1'b0, 1'($urandom_range(0, 1)));
            cycle($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 40) == 0,
                  1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bp_fpga_host_nbf_rx_packer.md
Name: bp_fpga_host_nbf_rx_packer

Overview:
- Sits between the UART receiver and the NBF command buffer on the host's inbound path.
- Consumes the deserialized UART byte stream from the PC host and packs consecutive bytes into complete NBF packets: 8-bit opcode + address + data, 112 bits at defaults.
- Presents each completed packet on a valid/yumi interface to the downstream NBF FIFO.
- Detects UART receive errors and inter-byte timeouts, discards the partial packet on either, and reports both via a sticky flag and a saturating counter.

Parameters:
nbf_addr_width_p, 40, NBF address width in bits; multiple of 8
nbf_data_width_p, 64, NBF data width in bits; multiple of 8
uart_data_bits_p, 8, byte width from the UART; must be 8
timeout_cycles_p, 1000000, idle cycles between bytes of one packet before the partial packet is discarded
(derived) nbf_width_lp = 8 + nbf_addr_width_p + nbf_data_width_p; nbf_bytes_lp = nbf_width_lp/8 (14 at defaults)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  asynchronous active-low reset
byte_i  in  8  received UART byte
byte_v_i  in  1  byte_i valid
byte_ready_and_o  out  1  packer accepts byte this cycle when byte_v_i & byte_ready_and_o
rx_error_i  in  1  one-cycle pulse: UART parity/framing error on the current byte
nbf_o  out  nbf_width_lp  assembled NBF packet
nbf_v_o  out  1  nbf_o valid
nbf_yumi_i  in  1  downstream consumes nbf_o; only legal while nbf_v_o=1
error_o  out  1  sticky: set on any discard; cleared only by reset
error_count_o  out  8  number of discarded partial packets, saturating at 255

Behaviour:
- Reset: one clock, clk_i; reset_n_i is asynchronous and active-low.
  - Asserting reset_n_i low immediately clears byte counter, accumulator, timeout counter, nbf_v_o, error_o and error_count_o.
  - byte_ready_and_o reads 0 while reset_n_i is low and 1 from the first edge after release.
  - Reset mid-packet or with nbf_v_o high drops all held data; nbf_o content is don't-care while nbf_v_o=0.
- Packing: byte number k of a packet (k=0 is the first byte after idle) lands in accumulator bits [8k+7:8k]. Stream order is little-endian over the whole packet, matching the NBF struct bit layout from bp_fpga_host_pkg.
- Storage: two stages, an accumulator plus a one-entry output register (nbf_o/nbf_v_o).
  - On acceptance of byte nbf_bytes_lp-1, the full packet, including that byte, moves to the output register on the same edge.
  - nbf_v_o rises the cycle after the final byte is accepted (latency 1).
  - The accumulator count returns to 0 on the same edge.
- byte_ready_and_o:
  - Deasserts only when count == nbf_bytes_lp-1, nbf_v_o=1 and nbf_yumi_i=0.
  - If nbf_yumi_i=1 in the same cycle, the final byte is accepted and the output register is refilled on that edge, so nbf_v_o stays 1. This gives back-to-back throughput.
- Output register: nbf_o is held stable while nbf_v_o=1 and not yumi'd. nbf_v_o falls the cycle after yumi unless it is refilled on the same edge.
- State machine:
  - e_idle, count=0, timer off.
  - e_recv, 0<count<nbf_bytes_lp. Each accepted byte increments count and zeroes the timer; otherwise the timer increments.
  - e_recv -> e_idle when the final byte is accepted (pushed to output), on a discard, or on reset.
- Discard conditions (both return to e_idle, zero count, set error_o and increment error_count_o with saturation; the output register is never affected):
  - rx_error_i=1 in any cycle. A byte presented in that same cycle is accepted but dropped. An error in e_idle still counts as a discard.
  - Timer reaches timeout_cycles_p-1 in e_recv. The timer is not started in e_idle.
  - Simultaneous rx_error_i and timeout in one cycle count as a single discard.
- Stall while waiting on ready: the timer does not advance while byte_v_i=1 and byte_ready_and_o=0, so backpressure never causes a timeout.
- Parameter checks: elaboration-time assertion that uart_data_bits_p==8 and that both widths are multiples of 8.

Test Plan:
- Single packet: send 14 bytes 0x00..0x0D with nbf_yumi_i held 1 -> nbf_v_o pulses 1 cycle after byte 13; nbf_o == 112'h0D0C...0100; error_count_o=0.
- Backpressure: nbf_yumi_i=0 and two packets streamed (second all 0xAA) -> byte_ready_and_o drops at byte 27 until yumi. The first packet is held stable; after yumi, nbf_o = all 0xAA bytes with no gap cycle.
- rx error mid-packet: rx_error_i pulsed with byte 5 -> partial packet discarded; error_o=1, error_count_o=1. The next 14 bytes form exactly one correct packet.
- Timeout: 3 bytes sent, then idle (timeout_cycles_p=100 in bench) -> discard after 100 idle cycles, error_count_o=1. The next 14 bytes yield one correct packet.
- Saturation and reset: 300 rx_error_i pulses -> error_count_o=255. Then assert reset_n_i asynchronously mid-packet, between clock edges -> all outputs 0 immediately.
- Combined: reset asserted with nbf_v_o=1 -> nbf_v_o=0 immediately. After release, a full packet is received correctly with no stale bytes.
